rotate_checker: RTL and testbench
=================================

Name: rotate_checker

Overview:
- Upstream feeder of the rotate executor. It decides whether the falling tile can rotate one step clockwise, and its result drives the executor's rotate-available input.
- On a request it computes the four cells of the tile at angle+1, bounds-checks each one, and reads the settled-cell board one row per cell through a synchronous RAM port.
- It reports avail (fits) or not-avail (collision or out of bounds) with a valid/yumi handshake.

Parameters:
- width_p, 16, board columns; each board row word is width_p bits, bit x set = occupied.
- height_p, 32, board rows.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- v_i  in  1  request valid; accepted only when ready_o=1.
- ready_o  out  1  high only in eIDLE.
- type_i  in  tile_type_e  current tile type.
- angle_i  in  2  current angle; target angle = angle_i+1 mod 4.
- pos_i  in  point_t  anchor (top-left of 4x4 box); x is $clog2(width_p) bits, y is $clog2(height_p) bits.
- rd_v_o  out  1  board row read strobe.
- rd_row_o  out  $clog2(height_p)  row address.
- rd_data_i  in  width_p  row data, valid the cycle after rd_v_o.
- v_o  out  1  result valid; held until yumi_i.
- avail_o  out  1  1 = rotation fits; meaningful only while v_o=1.
- yumi_i  in  1  consumer accepts the result.

Behaviour:
- Reset (reset_ni=0, any cycle, including mid-scan): state=eIDLE; v_o=0, avail_o=0, rd_v_o=0, rd_row_o=0; ready_o=1 once reset is released.
- Shape table: angle-0 offsets (dx,dy), dy grows downward:
  - I (0,1)(1,1)(2,1)(3,1)
  - O (1,0)(2,0)(1,1)(2,1)
  - T (1,0)(0,1)(1,1)(2,1)
  - S (1,0)(2,0)(0,1)(1,1)
  - Z (0,0)(1,0)(1,1)(2,1)
  - J (0,0)(0,1)(1,1)(2,1)
  - L (2,0)(0,1)(1,1)(2,1)
- Rotation: one clockwise step maps (dx,dy) to (3-dy,dx). Apply it target-angle times. Cell order is the table order, unchanged by rotation.
- Cell coordinates: cx = pos.x+dx and cy = pos.y+dy, each computed one bit wider than its field. A cell is out of bounds (OOB) if cx>=width_p or cy>=height_p.
- eNon: result is avail=0 with no reads.
- States:
  - eIDLE: on v_i, capture type, target angle and pos; k=0; go to eScan.
  - eScan (k=0..3), one cycle per cell.
    - If cell k is OOB: no read; set fail; go to eResp.
    - Otherwise: rd_v_o=1, rd_row_o=cy(k).
    - In the same cycle, if k>0, test rd_data_i[cx(k-1)]. If the bit is set: set fail; go to eResp (the read just issued is discarded).
    - If k=3 and neither abort applies, go to eLast.
  - eLast: test rd_data_i[cx(3)] → eResp.
  - eResp: v_o=1, avail_o=~fail, both stable. On yumi_i → eIDLE.
- Latency, counted from the acceptance edge (cycle 0):
  - No abort: eScan occupies cycles 1-4, eLast cycle 5, v_o=1 from cycle 6.
  - Abort detected at cycle n: v_o=1 at cycle n+1.
- Busy/back-pressure rules:
  - v_i while busy is ignored and not queued.
  - yumi_i outside eResp is ignored.
  - yumi_i in eResp with v_i in the same cycle: the request is not accepted, because ready_o=0 in that cycle.
- Board contents are assumed stable during a scan; the checker does not arbitrate writes.
- rd_v_o is 0 outside eScan; rd_row_o holds its last value.

Test Plan:
- Empty board; T, pos(5,10), angle 0 → reads rows 11,10,11,12 on cycles 1-4; v_o=1, avail_o=1 at cycle 6; hold until yumi_i, then ready_o=1 next cycle.
- Same as above, but board row 12 bit 7 set → cell 3 collides, detected in eLast; v_o=1 at cycle 6 with avail_o=0.
- I, pos(14,0), angle 1 (target 2, cell 0 at x=17) → OOB at cycle 1, no rd_v_o ever; v_o=1 at cycle 2, avail_o=0.
- I, pos(12,0), angle 0 (target 1, cells x=14) → avail_o=1.
  - Same with pos(13,28) → cell 3 has y=31, in bounds, avail_o=1.
  - Same with pos(13,29) → cell 3 has y=32, OOB at cycle 4, v_o=1 at cycle 5, avail_o=0.
- type eNon → avail_o=0, no reads.
- Back-pressure:
  - Hold yumi_i=0 for 10 cycles → v_o and avail_o stable.
  - Pulse v_i mid-scan → ignored; result reflects the first request only.
- Reset mid-scan: drop reset_ni asynchronously at cycle 3 → v_o and rd_v_o fall to 0 immediately (no clock edge needed); after release, a fresh request completes normally.

Source files
------------

// File: rtl/rotate_checker.sv
// Rotation-fit checker: walks the four cells of the tile at angle+1, bounds-checks
// each and probes the settled board one row per cell, then reports avail/not-avail.
package rotate_checker_pkg;
    localparam int unsigned BoardWidth  = 16;
    localparam int unsigned BoardHeight = 32;
    localparam int unsigned PosXW       = $clog2(BoardWidth);
    localparam int unsigned PosYW       = $clog2(BoardHeight);

    typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;

    typedef struct packed {
        logic [PosXW-1:0] x;
        logic [PosYW-1:0] y;
    } point_t;
endpackage

module rotate_checker
    import rotate_checker_pkg::*;
#(
    parameter int unsigned width_p  = BoardWidth,
    parameter int unsigned height_p = BoardHeight
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        v_i,
    output logic                        ready_o,
    input  tile_type_e                  type_i,
    input  logic [1:0]                  angle_i,
    input  point_t                      pos_i,
    output logic                        rd_v_o,
    output logic [$clog2(height_p)-1:0] rd_row_o,
    input  logic [width_p-1:0]          rd_data_i,
    output logic                        v_o,
    output logic                        avail_o,
    input  logic                        yumi_i
);
    localparam int unsigned XW = $clog2(width_p);
    localparam int unsigned YW = $clog2(height_p);

    typedef enum logic [1:0] {eIDLE, eScan, eLast, eResp} state_e;

    typedef struct packed {
        logic          oob;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cell_t;

    // Board coordinates of cell idx of tile t after rot clockwise steps, anchored at p.
    function automatic cell_t cell_f(input tile_type_e t, input logic [1:0] rot,
                                     input point_t p, input logic [1:0] idx);
        logic [15:0] shape;
        logic [3:0]  off;
        logic [1:0]  dx, dy, tmp;
        logic [XW:0] cx;
        logic [YW:0] cy;
        cell_t       c;
        case (t)
            eI:      shape = 16'h159D;
            eO:      shape = 16'h4859;
            eT:      shape = 16'h4159;
            eS:      shape = 16'h4815;
            eZ:      shape = 16'h0459;
            eJ:      shape = 16'h0159;
            eL:      shape = 16'h8159;
            default: shape = 16'h0000;
        endcase
        case (idx)
            2'd0:    off = shape[15:12];
            2'd1:    off = shape[11:8];
            2'd2:    off = shape[7:4];
            default: off = shape[3:0];
        endcase
        dx = off[3:2];
        dy = off[1:0];
        // (dx,dy) -> (3-dy,dx); 3-dy on two bits is ~dy
        for (int i = 0; i < 3; i++) begin
            if (i < int'(rot)) begin
                tmp = dx;
                dx  = ~dy;
                dy  = tmp;
            end
        end
        cx    = (XW+1)'(p.x) + (XW+1)'(dx);
        cy    = (YW+1)'(p.y) + (YW+1)'(dy);
        c.oob = (cx >= (XW+1)'(width_p)) || (cy >= (YW+1)'(height_p));
        c.x   = cx[XW-1:0];
        c.y   = cy[YW-1:0];
        return c;
    endfunction

    state_e        state_q, state_d;
    tile_type_e    type_q, type_d;
    logic [1:0]    rot_q, rot_d;
    point_t        pos_q, pos_d;
    logic [1:0]    k_q, k_d;
    logic [XW-1:0] row_x_q, row_x_d;
    logic [XW-1:0] chk_x_q, chk_x_d;
    logic          ready_q, ready_d;
    logic          rd_v_q, rd_v_d;
    logic [YW-1:0] rd_row_q, rd_row_d;
    logic          v_q, v_d;
    logic          avail_q, avail_d;

    cell_t         tgt;
    logic          hit;

    // Cell whose read is issued next: cell 0 of the request in eIDLE, else cell k+1.
    always_comb begin
        if (state_q == eIDLE) begin
            tgt = cell_f(type_i, angle_i + 2'd1, pos_i, 2'd0);
        end else begin
            tgt = cell_f(type_q, rot_q, pos_q, k_q + 2'd1);
        end
    end

    assign hit = rd_data_i[chk_x_q];

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        rot_d    = rot_q;
        pos_d    = pos_q;
        k_d      = k_q;
        row_x_d  = row_x_q;
        chk_x_d  = chk_x_q;
        ready_d  = ready_q;
        rd_v_d   = 1'b0;
        rd_row_d = rd_row_q;
        v_d      = v_q;
        avail_d  = avail_q;
        case (state_q)
            eIDLE: begin
                if (v_i) begin
                    type_d  = type_i;
                    rot_d   = angle_i + 2'd1;
                    pos_d   = pos_i;
                    k_d     = 2'd0;
                    ready_d = 1'b0;
                    if (type_i == eNon) begin
                        state_d = eResp;
                        v_d     = 1'b1;
                        avail_d = 1'b0;
                    end else begin
                        state_d = eScan;
                        rd_v_d  = ~tgt.oob;
                        if (!tgt.oob) begin
                            rd_row_d = tgt.y;
                            row_x_d  = tgt.x;
                        end
                    end
                end
            end
            eScan: begin
                chk_x_d = row_x_q;
                // No read in flight this cycle means cell k was out of bounds
                if (!rd_v_q || (k_q != 2'd0 && hit)) begin
                    state_d = eResp;
                    v_d     = 1'b1;
                    avail_d = 1'b0;
                end else if (k_q == 2'd3) begin
                    state_d = eLast;
                end else begin
                    k_d    = k_q + 2'd1;
                    rd_v_d = ~tgt.oob;
                    if (!tgt.oob) begin
                        rd_row_d = tgt.y;
                        row_x_d  = tgt.x;
                    end
                end
            end
            eLast: begin
                state_d = eResp;
                v_d     = 1'b1;
                avail_d = ~hit;
            end
            eResp: begin
                if (yumi_i) begin
                    state_d = eIDLE;
                    v_d     = 1'b0;
                    avail_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = eIDLE;
                ready_d = 1'b1;
                v_d     = 1'b0;
                avail_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= eIDLE;
            type_q   <= eNon;
            rot_q    <= '0;
            pos_q    <= '0;
            k_q      <= '0;
            row_x_q  <= '0;
            chk_x_q  <= '0;
            ready_q  <= 1'b1;
            rd_v_q   <= 1'b0;
            rd_row_q <= '0;
            v_q      <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            rot_q    <= rot_d;
            pos_q    <= pos_d;
            k_q      <= k_d;
            row_x_q  <= row_x_d;
            chk_x_q  <= chk_x_d;
            ready_q  <= ready_d;
            rd_v_q   <= rd_v_d;
            rd_row_q <= rd_row_d;
            v_q      <= v_d;
            avail_q  <= avail_d;
        end
    end

    assign ready_o  = ready_q;
    assign rd_v_o   = rd_v_q;
    assign rd_row_o = rd_row_q;
    assign v_o      = v_q;
    assign avail_o  = avail_q;

endmodule

// File: tb/tb_rotate_checker.sv
// Directed bench for rotate_checker: vector table plus back-pressure and reset sequences.
module tb_rotate_checker;
    import rotate_checker_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        v_i;
    logic        ready_o;
    tile_type_e  type_i;
    logic [1:0]  angle_i;
    point_t      pos_i;
    logic        rd_v_o;
    logic [4:0]  rd_row_o;
    logic [15:0] rd_data_i;
    logic        v_o;
    logic        avail_o;
    logic        yumi_i;

    logic [15:0] board [32];
    int          tests = 0;
    int          fails = 0;

    rotate_checker #(.width_p(16), .height_p(32)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .type_i   (type_i),
        .angle_i  (angle_i),
        .pos_i    (pos_i),
        .rd_v_o   (rd_v_o),
        .rd_row_o (rd_row_o),
        .rd_data_i(rd_data_i),
        .v_o      (v_o),
        .avail_o  (avail_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous board RAM: data valid the cycle after the strobe
    always @(posedge clk_i) begin
        if (rd_v_o) rd_data_i <= board[rd_row_o];
    end

    typedef struct {
        tile_type_e t;
        logic [1:0] ang;
        logic [3:0] x;
        logic [4:0] y;
        int         hit_row;
        int         hit_bit;
        logic       avail;
        int         lat;
        int         nrd;
        int         rows [4];
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < 32; r++) board[r] = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int hold,
                           input int pulse_cyc, input bit collide);
        int cyc;
        int rows_q [$];
        clear_board();
        if (v.hit_bit >= 0) board[v.hit_row][v.hit_bit] = 1'b1;
        @(negedge clk_i);
        type_i  = v.t;
        angle_i = v.ang;
        pos_i.x = v.x;
        pos_i.y = v.y;
        v_i     = 1'b1;
        chk({tag, "_ready_idle"}, 32'(ready_o), 32'd1);
        @(negedge clk_i);
        cyc = 1;
        forever begin
            v_i = (cyc == pulse_cyc);
            if (v_i) type_i = eNon;
            if (rd_v_o) rows_q.push_back(int'(rd_row_o));
            if (v_o || cyc >= 20) break;
            @(negedge clk_i);
            cyc++;
        end
        v_i = 1'b0;
        chk({tag, "_v_o_seen"}, 32'(v_o), 32'd1);
        if (v.lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(v.lat));
        chk({tag, "_avail"}, 32'(avail_o), 32'(v.avail));
        chk({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
        chk({tag, "_nreads"}, 32'(rows_q.size()), 32'(v.nrd));
        for (int i = 0; i < rows_q.size() && i < v.nrd; i++)
            chk($sformatf("%s_row%0d", tag, i), 32'(rows_q[i]), 32'(v.rows[i]));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            chk($sformatf("%s_hold%0d", tag, h), {30'd0, v_o, avail_o}, {30'd0, 1'b1, v.avail});
        end
        yumi_i = 1'b1;
        if (collide) begin
            v_i    = 1'b1;
            type_i = eT;
        end
        @(negedge clk_i);
        yumi_i = 1'b0;
        v_i    = 1'b0;
        chk({tag, "_ready_after_yumi"}, 32'(ready_o), 32'd1);
        chk({tag, "_v_o_dropped"}, 32'(v_o), 32'd0);
        if (collide) begin
            @(negedge clk_i);
            chk({tag, "_collide_no_start"}, {30'd0, rd_v_o, v_o}, 32'd0);
            chk({tag, "_collide_ready"}, 32'(ready_o), 32'd1);
        end
    endtask

    initial begin
        vecs[0]  = '{eT, 2'd0, 4'd5,  5'd10, 0,  -1, 1'b1, 6,  4, '{11, 10, 11, 12}};
        vecs[1]  = '{eT, 2'd0, 4'd5,  5'd10, 12,  7, 1'b0, 6,  4, '{11, 10, 11, 12}};
        vecs[2]  = '{eI, 2'd1, 4'd14, 5'd0,  0,  -1, 1'b0, 2,  0, '{0, 0, 0, 0}};
        vecs[3]  = '{eI, 2'd0, 4'd12, 5'd0,  0,  -1, 1'b1, 6,  4, '{0, 1, 2, 3}};
        vecs[4]  = '{eI, 2'd0, 4'd13, 5'd28, 0,  -1, 1'b1, 6,  4, '{28, 29, 30, 31}};
        vecs[5]  = '{eI, 2'd0, 4'd13, 5'd29, 0,  -1, 1'b0, 5,  3, '{29, 30, 31, 0}};
        vecs[6]  = '{eNon, 2'd0, 4'd0, 5'd0, 0,  -1, 1'b0, -1, 0, '{0, 0, 0, 0}};
        vecs[7]  = '{eT, 2'd0, 4'd5,  5'd10, 11,  8, 1'b0, 3,  2, '{11, 10, 0, 0}};
        vecs[8]  = '{eO, 2'd3, 4'd0,  5'd0,  0,  -1, 1'b1, 6,  4, '{0, 0, 1, 1}};
        vecs[9]  = '{eL, 2'd2, 4'd0,  5'd0,  1,   1, 1'b0, 6,  4, '{1, 3, 2, 1}};
        vecs[10] = '{eS, 2'd0, 4'd13, 5'd0,  0,  -1, 1'b0, 2,  0, '{0, 0, 0, 0}};

        reset_ni = 1'b0;
        v_i      = 1'b0;
        yumi_i   = 1'b0;
        type_i   = eNon;
        angle_i  = 2'd0;
        pos_i    = '0;
        clear_board();
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", {28'd0, v_o, avail_o, rd_v_o, 1'b0}, 32'd0);
        chk("reset_rd_row", 32'(rd_row_o), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_ready", 32'(ready_o), 32'd1);

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i), 0, 0, 1'b0);

        run_vec(vecs[0], "hold10", 10, 0, 1'b0);
        run_vec(vecs[0], "midscan_pulse", 0, 2, 1'b0);
        run_vec(vecs[3], "yumi_and_v", 0, 0, 1'b1);

        // Asynchronous reset while a read is outstanding
        clear_board();
        @(negedge clk_i);
        type_i  = eT;
        angle_i = 2'd0;
        pos_i.x = 4'd5;
        pos_i.y = 5'd10;
        v_i     = 1'b1;
        @(negedge clk_i);
        v_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("midreset_pre_rd_v", 32'(rd_v_o), 32'd1);
        chk("midreset_pre_row", 32'(rd_row_o), 32'd11);
        #1 reset_ni = 1'b0;
        #1;
        chk("midreset_rd_v", 32'(rd_v_o), 32'd0);
        chk("midreset_v_o", 32'(v_o), 32'd0);
        chk("midreset_rd_row", 32'(rd_row_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("midreset_ready", 32'(ready_o), 32'd1);
        run_vec(vecs[1], "after_reset", 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
